// File: rtl/binary_mul_16_1_bi_pkg.sv
// Shared widths, Booth select encoding and carry-save helper for the 16x16 signed multiplier.
package binary_mul_16_1_bi_pkg;

  localparam int A_W          = 16;
  localparam int B_W          = 16;
  localparam int P_W          = 31;
  localparam int BOOTH_DIGITS = 8;
  localparam int PP_W         = A_W + 1;
  localparam int ROWS         = BOOTH_DIGITS + 1;

  typedef logic [2:0] booth_code_t;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_sel_t;

  typedef struct packed {
    logic [P_W-1:0] s;
    logic [P_W-1:0] c;
  } csa_t;

  function automatic booth_sel_t booth_encode(input booth_code_t code);
    booth_sel_t sel;
    sel = '0;
    case (code)
      3'b001, 3'b010: sel.one = 1'b1;
      3'b011:         sel.two = 1'b1;
      3'b100:         begin sel.two = 1'b1; sel.neg = 1'b1; end
      3'b101, 3'b110: begin sel.one = 1'b1; sel.neg = 1'b1; end
      default:        sel = '0;
    endcase
    return sel;
  endfunction

  // Product only keeps 31 bits, so the carry out of bit 30 is simply dropped.
  function automatic csa_t csa3(input logic [P_W-1:0] x, input logic [P_W-1:0] y,
                                input logic [P_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_r4_pp_gen.sv
// One radix-4 Booth digit: selects 0, +-A or +-2A from a 3-bit multiplier window.
module booth_r4_pp_gen
  import binary_mul_16_1_bi_pkg::*;
(
  input  logic [A_W-1:0]  a,
  input  booth_code_t     code,
  output logic [PP_W-1:0] pp,
  output logic            neg
);

  booth_sel_t      sel;
  logic [PP_W-1:0] mag;

  // Negation is invert here plus a +1 injected by the top as a separate bit.
  always_comb begin
    sel = booth_encode(code);
    mag = '0;
    if (sel.two)
      mag = {a, 1'b0};
    else if (sel.one)
      mag = {a[A_W-1], a};
    pp  = sel.neg ? ~mag : mag;
    neg = sel.neg;
  end

endmodule

// File: rtl/binary_mul_16_1_bi.sv
// Signed 16x16 multiplier: Booth radix-4 partial products, CSA tree, final add, one output register.
module binary_mul_16_1_bi
  import binary_mul_16_1_bi_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [A_W-1:0] A,
  input  logic [B_W-1:0] B,
  output logic [P_W-1:0] P
);

  logic [B_W:0]    b_ext;
  logic [PP_W-1:0] pp   [BOOTH_DIGITS];
  logic            neg  [BOOTH_DIGITS];
  logic [P_W-1:0]  rows [ROWS];
  csa_t            l1_0, l1_1, l1_2, l2_0, l2_1, l3_0, l4_0;
  logic [P_W-1:0]  sum;
  logic [P_W-1:0]  p_d, p_q;

  assign b_ext = {B, 1'b0};

  for (genvar i = 0; i < BOOTH_DIGITS; i++) begin : g_pp
    booth_r4_pp_gen u_pp (
      .a    (A),
      .code (b_ext[2*i+2 -: 3]),
      .pp   (pp[i]),
      .neg  (neg[i])
    );
  end

  // Nine rows (eight shifted digits plus the collected +1 bits) reduce 9->6->4->3->2.
  always_comb begin
    for (int i = 0; i < BOOTH_DIGITS; i++)
      rows[i] = {{(P_W-PP_W){pp[i][PP_W-1]}}, pp[i]} << (2*i);
    rows[BOOTH_DIGITS] = '0;
    for (int i = 0; i < BOOTH_DIGITS; i++)
      rows[BOOTH_DIGITS][2*i] = neg[i];

    l1_0 = csa3(rows[0], rows[1], rows[2]);
    l1_1 = csa3(rows[3], rows[4], rows[5]);
    l1_2 = csa3(rows[6], rows[7], rows[8]);
    l2_0 = csa3(l1_0.s, l1_0.c, l1_1.s);
    l2_1 = csa3(l1_1.c, l1_2.s, l1_2.c);
    l3_0 = csa3(l2_0.s, l2_0.c, l2_1.s);
    l4_0 = csa3(l3_0.s, l3_0.c, l2_1.c);
    sum  = l4_0.s + l4_0.c;

    p_d = en ? sum : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      p_q <= '0;
    else
      p_q <= p_d;
  end

  assign P = p_q;

endmodule

// File: tb/tb_binary_mul_16_1_bi.sv
// Directed and swept checks of the registered signed 16x16 multiplier.
module tb_binary_mul_16_1_bi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [30:0] P;

  int checks = 0;
  int passes = 0;

  binary_mul_16_1_bi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [30:0] act, input logic [30:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               tag, $signed(act), act, $signed(exp), exp);
    else
      passes++;
  endtask

  // Drive operands at the falling edge, then sample just after the next rising edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic e);
    @(negedge clk);
    A  = a;
    B  = b;
    en = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] model(input logic [15:0] a, input logic [15:0] b);
    int prod;
    prod = int'($signed(a)) * int'($signed(b));
    return prod[30:0];
  endfunction

  logic [15:0] bnd [11] = '{16'h8000, 16'h8001, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002,
                            16'h7FFE, 16'h7FFF, 16'hFFFE, 16'h5555, 16'hAAAA};

  initial begin
    logic [15:0] ra, rb;

    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", P, 31'd0);
    A  = 16'd1234;
    B  = 16'd5678;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_held", P, 31'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkOutput("reset_release", P, 31'd7006652);

    applyStimulus(16'd3, -16'sd7, 1'b1);
    checkOutput("q_pos_neg", P, 31'h7FFF_FFEB);
    applyStimulus(-16'sd3, -16'sd7, 1'b1);
    checkOutput("q_neg_neg", P, 31'd21);
    applyStimulus(16'h8000, 16'h7FFF, 1'b1);
    checkOutput("q_min_max", P, 31'h4000_8000);
    applyStimulus(16'h7FFF, 16'h7FFF, 1'b1);
    checkOutput("q_max_max", P, 31'd1073676289);
    applyStimulus(16'h8000, 16'h8000, 1'b1);
    checkOutput("wrap_min_min", P, 31'h4000_0000);
    applyStimulus(16'd0, 16'hFFFF, 1'b1);
    checkOutput("zero_a", P, 31'd0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
    checkOutput("neg1_neg1", P, 31'd1);

    applyStimulus(-16'sd3, -16'sd7, 1'b1);
    checkOutput("hold_pre", P, 31'd21);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'd100, 16'd100, 1'b0);
      checkOutput("hold", P, 31'd21);
    end
    applyStimulus(16'd100, 16'd100, 1'b1);
    checkOutput("hold_release", P, 31'd10000);

    // Asynchronous clear between edges, then restart on the first enabled edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("mid_reset", P, 31'd0);
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'd12;
    B = -16'sd12;
    @(posedge clk);
    #1 checkOutput("post_reset", P, 31'h7FFF_FF70);

    for (int i = 0; i < 32; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb, 1'b1);
      checkOutput("pipeline", P, model(ra, rb));
    end

    foreach (bnd[i]) begin
      foreach (bnd[j]) begin
        applyStimulus(bnd[i], bnd[j], 1'b1);
        checkOutput("boundary", P, model(bnd[i], bnd[j]));
      end
    end

    for (int i = 0; i < 4000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      applyStimulus(ra, rb, 1'b1);
      checkOutput("sweep", P, model(ra, rb));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
